sin_sweep_capture: RTL and testbench
====================================

Name: sin_sweep_capture

Overview:
- Stimulus/readback end of the FPGA function-evaluation harness.
- Drives a 12-bit input code onto the device-under-test input pins and waits a programmable settle time.
- Samples the 6-bit response pins and queues {code, response} pairs in a small FIFO, drained over a valid/ready stream.
- Sweeps a configurable code range per start command and applies backpressure by stalling the sweep.

Parameters:
- IN_W, 12: stimulus code width.
- OUT_W, 6: response width.
- SETTLE, 4: cycles between driving a code and sampling the response; must be >= 1.
- NUM_POINTS, 4096: codes per sweep; must be >= 1.
- FIFO_DEPTH, 8: result FIFO entries; must be a power of 2, >= 2.

Ports:
- clk, input, 1: sole clock; all logic on its rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: begin a sweep; sampled only in IDLE.
- abort, input, 1: synchronous abort; highest priority after reset.
- start_code, input, IN_W: first code of the sweep, latched on accepted start.
- step, input, IN_W: code increment, latched on accepted start.
- busy, output, 1: high in any state other than IDLE.
- done, output, 1: one-cycle pulse when the final point has been queued.
- stim, output, IN_W: code driven to the device-under-test pins.
- resp, input, OUT_W: device-under-test response pins.
- m_valid, output, 1: FIFO head is valid.
- m_ready, input, 1: consumer accepts the head.
- m_code, output, IN_W: code of the head entry.
- m_data, output, OUT_W: response of the head entry.

Behaviour:
- Reset (async assert, sync release) sets state IDLE, stim=0, busy=0, done=0, FIFO empty, m_valid=0, m_code=0, m_data=0, and all counters to 0.
- States are IDLE, SETTLE, CAPTURE and DONE.
- IDLE:
  - start=1 latches start_code and step, sets stim=start_code and point counter=0, then goes to SETTLE on the next cycle.
  - start is ignored in every other state.
- SETTLE: the settle counter runs 0 to SETTLE-1, then the block goes to CAPTURE. stim holds steady throughout.
- CAPTURE, FIFO not full:
  - Writes {stim, resp} into the FIFO, with resp sampled this cycle.
  - If point counter == NUM_POINTS-1, goes to DONE.
  - Otherwise sets stim <= stim+step (mod 2^IN_W, silent wrap), increments the counter and goes to SETTLE.
- CAPTURE, FIFO full: holds state, stim and counter; no write; resp is re-sampled each cycle until space frees.
- Full is evaluated before the same-cycle pop, so a simultaneous pop does not enable the push.
- Latency from start to the first capture is 1+SETTLE cycles. Each point costs SETTLE+1 cycles when unstalled.
- DONE: done=1 for exactly one cycle, then IDLE. stim keeps its last code.
- FIFO:
  - First-word fall-through: m_valid, m_code and m_data reflect the head combinationally from registers.
  - A pop occurs when m_valid && m_ready.
  - A push and pop in the same cycle on a non-full FIFO keeps the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- abort=1 in any state: next cycle goes to IDLE, FIFO flushed, done not pulsed, stim retained. abort in IDLE only flushes the FIFO.
- Reset asserted mid-sweep clears everything immediately; no partial entry remains.

Optional Feature:
- Macro: SWEEP_CHECKSUM_EN.
- When defined:
  - Adds output port checksum, 16 bits.
  - checksum is cleared on accepted start and on reset.
  - Adds each queued response, zero-extended, mod 2^16 on every FIFO push.
  - Valid when done pulses and held until the next start.
  - abort clears it.
- When undefined: no port and no logic.

Test Plan:
- Basic sweep. Setup: NUM_POINTS=8, start_code=0, step=1, resp=stim[5:0], m_ready=1. Required: 8 entries (0,0)…(7,7) in order; first m_valid 6 cycles after start; done pulses once; busy falls with done.
- Wrap. Setup: start_code=12'hFFE, step=1, NUM_POINTS=4. Required: codes FFE, FFF, 000, 001; resp values 3E, 3F, 00, 01.
- Backpressure. Setup: m_ready=0, NUM_POINTS=12, FIFO_DEPTH=8. Required: stim stalls on code 8 with busy=1. Then m_ready=1 yields all 12 entries in order with no loss or duplication, and done pulses once.
- Abort. Setup: abort at point 3 of 8. Required: busy=0 and m_valid=0 next cycle; done never pulses; a new start restarts from the freshly latched start_code.
- Start while busy and async reset. Setup: pulse start mid-sweep. Required: no effect. Then assert rst_n=0 between clock edges. Required: stim=0, busy=0 and m_valid=0 immediately.
- Checksum. Setup: SWEEP_CHECKSUM_EN, start_code=0, step=1, NUM_POINTS=8, loopback. Required: checksum=16'd28 at done.

Source files
------------

// File: rtl/sin_sweep_capture.sv
// Code sweep driver with settle/capture and a first-word fall-through result FIFO.
// Optional SWEEP_CHECKSUM_EN adds a running 16-bit sum of queued responses.
module sin_sweep_capture #(
   parameter int IN_W       = 12,
   parameter int OUT_W      = 6,
   parameter int SETTLE     = 4,
   parameter int NUM_POINTS = 4096,
   parameter int FIFO_DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [IN_W-1:0]  start_code,
   input  logic [IN_W-1:0]  step,
   output logic             busy,
   output logic             done,
   output logic [IN_W-1:0]  stim,
   input  logic [OUT_W-1:0] resp,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [IN_W-1:0]  m_code,
   output logic [OUT_W-1:0] m_data
`ifdef SWEEP_CHECKSUM_EN
   ,
   output logic [15:0]      checksum
`endif
);

   localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int PCW = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;
   localparam int EW  = IN_W + OUT_W;

   localparam logic [SCW-1:0] SET_LAST = SCW'(SETTLE - 1);
   localparam logic [PCW-1:0] PT_LAST  = PCW'(NUM_POINTS - 1);
   localparam logic [CW-1:0]  FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_CAPT,
      S_DONE
   } state_e;

   state_e          state_q, state_d;
   logic [IN_W-1:0] stim_q, stim_d;
   logic [IN_W-1:0] step_q, step_d;
   logic [SCW-1:0]  scnt_q, scnt_d;
   logic [PCW-1:0]  pcnt_q, pcnt_d;
   logic [EW-1:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_q, wr_d;
   logic [AW-1:0]   rd_q, rd_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [EW-1:0]   head;
   logic            accept, full, push, pop;

   assign accept = (state_q == S_IDLE) && start && !abort;
   // Full is taken from the registered count, so a same-cycle pop cannot admit a push.
   assign full   = (cnt_q == FULL_CNT);
   assign push   = (state_q == S_CAPT) && !full && !abort;
   assign pop    = m_valid && m_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) state_d = S_SETTLE;
            end
            S_SETTLE: begin
               if (scnt_q == SET_LAST) state_d = S_CAPT;
            end
            S_CAPT: begin
               if (!full) begin
                  state_d = (pcnt_q == PT_LAST) ? S_DONE : S_SETTLE;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      busy = (state_q != S_IDLE);
      done = (state_q == S_DONE);
   end

   always_comb begin
      stim_d = stim_q;
      step_d = step_q;
      scnt_d = '0;
      pcnt_d = pcnt_q;
      if (accept) begin
         stim_d = start_code;
         step_d = step;
         pcnt_d = '0;
      end
      if ((state_q == S_SETTLE) && !abort) begin
         scnt_d = scnt_q + SCW'(1);
      end
      if (push && (pcnt_q != PT_LAST)) begin
         stim_d = stim_q + step_q;
         pcnt_d = pcnt_q + PCW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stim_q <= '0;
         step_q <= '0;
         scnt_q <= '0;
         pcnt_q <= '0;
      end else begin
         stim_q <= stim_d;
         step_q <= step_d;
         scnt_q <= scnt_d;
         pcnt_q <= pcnt_d;
      end
   end

   always_comb begin
      wr_d  = wr_q + AW'(push);
      rd_d  = rd_q + AW'(pop);
      cnt_d = cnt_q;
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
      if (abort) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset: the count gates visibility of every slot.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= {stim_q, resp};
   end

   assign head             = mem_q[rd_q];
   assign m_valid          = (cnt_q != '0);
   assign {m_code, m_data} = m_valid ? head : '0;
   assign stim             = stim_q;

`ifdef SWEEP_CHECKSUM_EN
   logic [15:0] csum_q, csum_d;

   always_comb begin
      csum_d = csum_q;
      if (abort || accept) begin
         csum_d = '0;
      end else if (push) begin
         csum_d = csum_q + 16'(resp);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum_q <= '0;
      end else begin
         csum_q <= csum_d;
      end
   end

   assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_sin_sweep_capture.sv
// Bench for sin_sweep_capture: loopback responses, queue model of the
// expected {code, response} stream, directed sweep/stall/abort/reset cases.
module tb_sin_sweep_capture;

   localparam int IN_W  = 12;
   localparam int OUT_W = 6;
   localparam int NP    = 12;
   localparam int FD    = 8;
   localparam int EW    = IN_W + OUT_W;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic             m_ready = 1'b0;
   logic [IN_W-1:0]  start_code = '0;
   logic [IN_W-1:0]  step = '0;
   logic [IN_W-1:0]  stim, m_code;
   logic [OUT_W-1:0] resp, m_data;
   logic             busy, done, m_valid;
`ifdef SWEEP_CHECKSUM_EN
   logic [15:0]      checksum;
`endif

   int total = 0;
   int passed = 0;
   int ndone = 0;
   logic [EW-1:0] expq[$];
   logic [EW-1:0] got[$];

   sin_sweep_capture #(
      .IN_W      (IN_W),
      .OUT_W     (OUT_W),
      .SETTLE    (4),
      .NUM_POINTS(NP),
      .FIFO_DEPTH(FD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .start_code(start_code),
      .step      (step),
      .busy      (busy),
      .done      (done),
      .stim      (stim),
      .resp      (resp),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_code    (m_code),
      .m_data    (m_data)
`ifdef SWEEP_CHECKSUM_EN
      ,
      .checksum  (checksum)
`endif
   );

   always #5 clk = ~clk;

   // Loopback: the device under test answers with the low code bits.
   assign resp = stim[OUT_W-1:0];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Expected stream: code_i = start + i*step mod 2^IN_W, resp = low bits.
   task automatic model_sweep(input logic [IN_W-1:0] sc,
                              input logic [IN_W-1:0] st);
      logic [IN_W-1:0] c;
      for (int i = 0; i < NP; i++) begin
         c = sc + IN_W'(i) * st;
         expq.push_back({c, c[OUT_W-1:0]});
      end
   endtask

   task automatic do_start(input logic [IN_W-1:0] sc,
                           input logic [IN_W-1:0] st);
      @(posedge clk);
      #1;
      start_code = sc;
      step = st;
      start = 1'b1;
      model_sweep(sc, st);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output logic b, output logic [15:0] cs);
      logic seen;
      seen = 1'b0;
      b = 1'b0;
      cs = '0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            b = busy;
`ifdef SWEEP_CHECKSUM_EN
            cs = checksum;
`endif
         end
      end
      chk("done_seen", 32'(seen), 32'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && expq.size() != 0; i++) begin
         @(negedge clk);
      end
      chk("drained", 32'(expq.size()), 32'd0);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (done) ndone++;
         if (m_valid && m_ready) begin
            chk("pop_model_nonempty", 32'(expq.size() != 0), 32'd1);
            if (expq.size() != 0) begin
               chk("pop_code", 32'(m_code), 32'(expq[0][EW-1:OUT_W]));
               chk("pop_data", 32'(m_data), 32'(expq[0][OUT_W-1:0]));
               got.push_back({m_code, m_data});
               void'(expq.pop_front());
            end
         end
      end
   end

   initial begin
      logic        b;
      logic [15:0] cs;
      int          lat;
      int          msum;

      #1 rst_n = 1'b0;
      #11;
      chk("rst_stim", 32'(stim), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_valid", 32'(m_valid), 32'd0);
      chk("rst_code", 32'(m_code), 32'd0);
      chk("rst_data", 32'(m_data), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic sweep
      @(posedge clk);
      #1 m_ready = 1'b1;
      got.delete();
      ndone = 0;
      do_start(12'h000, 12'h001);
      msum = 0;
      foreach (expq[k]) msum += int'(expq[k][OUT_W-1:0]);
      chk("model_resp_sum", 32'(msum), 32'd66);
      lat = 0;
      for (int i = 0; i < 20 && !m_valid; i++) begin
         @(negedge clk);
         lat++;
      end
      chk("first_valid_latency", 32'(lat), 32'd6);
      wait_done(b, cs);
      chk("busy_at_done", 32'(b), 32'd1);
`ifdef SWEEP_CHECKSUM_EN
      chk("checksum_at_done", 32'(cs), 32'd66);
`endif
      @(negedge clk);
      chk("busy_after_done", 32'(busy), 32'd0);
      chk("done_one_cycle", 32'(done), 32'd0);
      drain();
      chk("basic_count", 32'(got.size()), 32'd12);
      chk("basic_first", 32'(got[0]), 32'({12'h000, 6'h00}));
      chk("basic_last", 32'(got[11]), 32'({12'h00B, 6'h0B}));
      chk("basic_ndone", 32'(ndone), 32'd1);
`ifdef SWEEP_CHECKSUM_EN
      chk("checksum_held", 32'(checksum), 32'd66);
`endif

      // Wrap through the top of the code space
      got.delete();
      ndone = 0;
      do_start(12'hFFE, 12'h001);
      wait_done(b, cs);
      drain();
      chk("wrap_0", 32'(got[0]), 32'({12'hFFE, 6'h3E}));
      chk("wrap_1", 32'(got[1]), 32'({12'hFFF, 6'h3F}));
      chk("wrap_2", 32'(got[2]), 32'({12'h000, 6'h00}));
      chk("wrap_3", 32'(got[3]), 32'({12'h001, 6'h01}));
      chk("wrap_count", 32'(got.size()), 32'd12);
      chk("stim_retained", 32'(stim), 32'h009);

      // Backpressure stalls the sweep on the ninth code
      @(posedge clk);
      #1 m_ready = 1'b0;
      got.delete();
      ndone = 0;
      do_start(12'h000, 12'h001);
      repeat (70) @(negedge clk);
      chk("stall_stim", 32'(stim), 32'h008);
      chk("stall_busy", 32'(busy), 32'd1);
      chk("stall_valid", 32'(m_valid), 32'd1);
      repeat (10) @(negedge clk);
      chk("stall_hold", 32'(stim), 32'h008);
      chk("stall_no_done", 32'(ndone), 32'd0);
      @(posedge clk);
      #1 m_ready = 1'b1;
      wait_done(b, cs);
      drain();
      chk("bp_count", 32'(got.size()), 32'd12);
      chk("bp_entry8", 32'(got[8]), 32'({12'h008, 6'h08}));
      chk("bp_ndone", 32'(ndone), 32'd1);

      // Abort at point 3, then restart
      got.delete();
      ndone = 0;
      do_start(12'h000, 12'h001);
      lat = 0;
      while (stim != 12'h003 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("abort_reach_pt3", 32'(stim), 32'h003);
      @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      expq.delete();
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_valid", 32'(m_valid), 32'd0);
`ifdef SWEEP_CHECKSUM_EN
      chk("abort_checksum", 32'(checksum), 32'd0);
`endif
      repeat (30) @(negedge clk);
      chk("abort_no_done", 32'(ndone), 32'd0);
      chk("abort_stays_empty", 32'(m_valid), 32'd0);
      got.delete();
      do_start(12'h100, 12'h002);
      wait_done(b, cs);
      drain();
      chk("restart_0", 32'(got[0]), 32'({12'h100, 6'h00}));
      chk("restart_1", 32'(got[1]), 32'({12'h102, 6'h02}));
      chk("restart_count", 32'(got.size()), 32'd12);

      // Start while busy is ignored, then async reset mid-sweep
      got.delete();
      ndone = 0;
      do_start(12'h020, 12'h003);
      repeat (12) @(negedge clk);
      @(posedge clk);
      #1;
      start_code = 12'h555;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (30) @(negedge clk);
      chk("busy_start_busy", 32'(busy), 32'd1);
      chk("busy_start_entry2", 32'(got[2]), 32'({12'h026, 6'h26}));
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_stim", 32'(stim), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_valid", 32'(m_valid), 32'd0);
      chk("async_rst_code", 32'(m_code), 32'd0);
      expq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("no_partial_entry", 32'(m_valid), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
